// File: rtl/pearson_pkg.sv
// Shared encodings for the Pearson permutation-table RAM: opcodes, FSM states, fill modes.
package pearson_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam int INIT_IDENTITY = 0;
  localparam int INIT_ZERO     = 1;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SW_RDB,
    SW_WRA,
    SW_WRB
  } pearson_state_e;

endpackage

// File: rtl/pearson_mem_core.sv
// Single-port synchronous table storage with registered read data; the array has no reset.
module pearson_mem_core #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read-before-write: a write cycle returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pearson_table_ram.sv
// Pearson permutation-table RAM: self-initialising table with READ, WRITE and atomic SWAP.
//
// state  | meaning
// INIT   | filling the table, one word per cycle
// IDLE   | ready; READ/WRITE complete in one cycle, SWAP starts here
// SW_RDB | operand A word arriving from the array, reading operand B
// SW_WRA | writing operand B's word to address A
// SW_WRB | writing operand A's word to address B, done pulse follows
module pearson_table_ram
  import pearson_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int INIT_MODE  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [1:0]            op_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  done_o,
  output logic                  init_done_o
);

  pearson_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
  logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0] tmp_a_q, tmp_a_d;
  logic [DATA_WIDTH-1:0] rdata_hold_q, rdata_hold_d;
  logic                  rvalid_q, rvalid_d;
  logic                  done_q, done_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  pearson_mem_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    tmp_a_d      = tmp_a_q;
    rvalid_d     = 1'b0;
    done_d       = 1'b0;
    rdata_hold_d = rvalid_q ? mem_rdata : rdata_hold_q;
    mem_we       = 1'b0;
    mem_addr     = addr_a_i;
    mem_wdata    = wdata_i;
    case (state_q)
      INIT: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = (INIT_MODE == INIT_IDENTITY) ? DATA_WIDTH'(cnt_q) : '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (req_i) begin
          case (op_i)
            OP_READ:  rvalid_d = 1'b1;
            OP_WRITE: mem_we   = 1'b1;
            OP_SWAP: begin
              addr_a_d = addr_a_i;
              addr_b_d = addr_b_i;
              state_d  = SW_RDB;
            end
            default: ;
          endcase
        end
      end
      // The array's registered output carries A's word here and B's word in SW_WRA.
      SW_RDB: begin
        mem_addr = addr_b_q;
        tmp_a_d  = mem_rdata;
        state_d  = SW_WRA;
      end
      SW_WRA: begin
        mem_we    = 1'b1;
        mem_addr  = addr_a_q;
        mem_wdata = mem_rdata;
        state_d   = SW_WRB;
      end
      SW_WRB: begin
        mem_we    = 1'b1;
        mem_addr  = addr_b_q;
        mem_wdata = tmp_a_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      tmp_a_q      <= '0;
      rdata_hold_q <= '0;
      rvalid_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      tmp_a_q      <= tmp_a_d;
      rdata_hold_q <= rdata_hold_d;
      rvalid_q     <= rvalid_d;
      done_q       <= done_d;
    end
  end

  // Show fresh array data in the valid cycle, then keep the last read word.
  assign rdata_o     = rvalid_q ? mem_rdata : rdata_hold_q;
  assign rvalid_o    = rvalid_q;
  assign done_o      = done_q;
  assign ready_o     = (state_q == IDLE);
  assign init_done_o = (state_q != INIT);

endmodule

// File: tb/tb_pearson_table_ram.sv
// Randomised self-checking bench for pearson_table_ram against an array model of the table.
module tb_pearson_table_ram;

  logic       clk = 1'b0;
  logic       rst, req;
  logic [1:0] op;
  logic [7:0] addr_a, addr_b, wdata;
  logic       ready, rvalid, done, init_done;
  logic [7:0] rdata;

  logic        rst2, req2;
  logic [1:0]  op2;
  logic [3:0]  addr_a2, addr_b2;
  logic [15:0] wdata2;
  logic        ready2, rvalid2, done2, init_done2;
  logic [15:0] rdata2;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  ref_mem [256];
  logic [15:0] ref_mem2 [16];
  logic [7:0]  last_rd;

  always #5 clk = ~clk;

  pearson_table_ram dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .addr_a_i(addr_a), .addr_b_i(addr_b),
    .wdata_i(wdata), .ready_o(ready), .rdata_o(rdata), .rvalid_o(rvalid), .done_o(done),
    .init_done_o(init_done)
  );

  pearson_table_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .INIT_MODE(1)) dut2 (
    .clk_i(clk), .rst_i(rst2), .req_i(req2), .op_i(op2), .addr_a_i(addr_a2), .addr_b_i(addr_b2),
    .wdata_i(wdata2), .ready_o(ready2), .rdata_o(rdata2), .rvalid_o(rvalid2), .done_o(done2),
    .init_done_o(init_done2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_identity();
    for (int i = 0; i < 256; i++) ref_mem[i] = i[7:0];
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!ready && n < 400) begin cyc(); n++; end
    n_cmp++; if (n !== 256) begin n_err++; $display("FAIL %s_init_cycles: got %0d expected 256", name, n); end
    n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL %s_init_done: got %b expected 1", name, init_done); end
  endtask

  task automatic do_read(input logic [7:0] a);
    op = 2'b00; addr_a = a; req = 1'b1;
    cyc(); req = 1'b0;
    n_cmp++; if (rvalid !== 1'b1) begin n_err++; $display("FAIL read_rvalid @%h: got %b expected 1", a, rvalid); end
    n_cmp++; if (rdata !== ref_mem[a]) begin n_err++; $display("FAIL read_data @%h: got %h expected %h", a, rdata, ref_mem[a]); end
    last_rd = ref_mem[a];
    cyc();
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL read_pulse @%h: got %b expected 0", a, rvalid); end
    n_cmp++; if (rdata !== last_rd) begin n_err++; $display("FAIL read_hold @%h: got %h expected %h", a, rdata, last_rd); end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    op = 2'b01; addr_a = a; wdata = d; req = 1'b1;
    cyc(); req = 1'b0;
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL write_rvalid @%h: got %b expected 0", a, rvalid); end
    ref_mem[a] = d;
  endtask

  task automatic do_swap(input logic [7:0] a, input logic [7:0] b, input bit poke);
    logic [7:0] t;
    op = 2'b10; addr_a = a; addr_b = b; req = 1'b1;
    cyc();
    if (poke) begin op = 2'b01; wdata = 8'h99; end else req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) cyc();
      if (k == 2) req = 1'b0;
      n_cmp++; if (ready !== 1'b0 || done !== 1'b0 || rvalid !== 1'b0) begin
        n_err++; $display("FAIL swap_busy%0d: got ready=%b done=%b rvalid=%b expected 0,0,0", k, ready, done, rvalid);
      end
    end
    cyc();
    n_cmp++; if (ready !== 1'b1 || done !== 1'b1 || rvalid !== 1'b0) begin
      n_err++; $display("FAIL swap_done: got ready=%b done=%b rvalid=%b expected 1,1,0", ready, done, rvalid);
    end
    cyc();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL swap_done_pulse: got %b expected 0", done); end
    t = ref_mem[a]; ref_mem[a] = ref_mem[b]; ref_mem[b] = t;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; op = 2'b00; addr_a = '0; addr_b = '0; wdata = '0;
    cyc(); cyc();
    n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", ready); end
    n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done: got %b expected 0", init_done); end
    n_cmp++; if (rvalid !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rst_pulses: got rvalid=%b done=%b expected 0,0", rvalid, done); end
    n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h expected 00", rdata); end
    rst = 1'b0; req = 1'b1; addr_a = 8'h33;
    wait_init("reset");
    req = 1'b0;
    n_cmp++; if (rvalid !== 1'b0) begin n_err++; $display("FAIL init_req_ignored: got rvalid=%b expected 0", rvalid); end
    model_identity();
    last_rd = 8'h00;
  endtask

  task automatic test_read_identity();
    do_read(8'h00); do_read(8'h7F); do_read(8'hFF);
    for (int i = 0; i < 5; i++) do_read(8'($urandom));
  endtask

  task automatic test_write_then_read();
    do_write(8'h10, 8'h3C);
    do_read(8'h10);
    op = 2'b00; addr_a = 8'h10; req = 1'b1;
    cyc();
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 8'h3C) begin n_err++; $display("FAIL b2b_first: got rvalid=%b rdata=%h expected 1,3c", rvalid, rdata); end
    addr_a = 8'h11;
    cyc(); req = 1'b0;
    n_cmp++; if (rvalid !== 1'b1 || rdata !== 8'h11) begin n_err++; $display("FAIL b2b_second: got rvalid=%b rdata=%h expected 1,11", rvalid, rdata); end
    last_rd = 8'h11;
  endtask

  task automatic test_swap();
    do_swap(8'h05, 8'hFA, 1'b1);
    do_read(8'h05); do_read(8'hFA);
  endtask

  task automatic test_swap_same_and_rsvd();
    do_swap(8'h20, 8'h20, 1'b0);
    op = 2'b11; addr_a = 8'h20; wdata = 8'h55; req = 1'b1;
    cyc(); req = 1'b0;
    n_cmp++; if (rvalid !== 1'b0 || done !== 1'b0 || ready !== 1'b1) begin
      n_err++; $display("FAIL rsvd_op: got rvalid=%b done=%b ready=%b expected 0,0,1", rvalid, done, ready);
    end
    n_cmp++; if (ref_mem[8'h20] !== 8'h20) begin n_err++; $display("FAIL rsvd_model: got %h expected 20", ref_mem[8'h20]); end
    do_read(8'h20);
  endtask

  task automatic test_random_mix();
    logic [7:0] a, d;
    int sel;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 2);
      a = 8'($urandom); d = 8'($urandom);
      op = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b01 : 2'b11;
      addr_a = a; wdata = d; req = 1'b1;
      cyc();
      if (sel == 0) last_rd = ref_mem[a];
      if (sel == 1) ref_mem[a] = d;
      n_cmp++; if (rvalid !== (sel == 0) || rdata !== last_rd) begin
        n_err++; $display("FAIL mix_%0d op=%0d @%h: got rvalid=%b rdata=%h expected %b,%h", i, sel, a, rvalid, rdata, sel == 0, last_rd);
      end
    end
    req = 1'b0;
    cyc();
    for (int i = 0; i < 6; i++) do_swap(8'($urandom), 8'($urandom), i[0]);
    for (int i = 0; i < 10; i++) do_read(8'($urandom));
  endtask

  task automatic test_reset_mid_swap();
    do_write(8'h01, 8'hA1);
    op = 2'b10; addr_a = 8'h01; addr_b = 8'h02; req = 1'b1;
    cyc(); req = 1'b0; rst = 1'b1;
    cyc();
    n_cmp++; if (ready !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midswap_rst: got ready=%b done=%b expected 0,0", ready, done); end
    n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL midswap_rdata: got %h expected 00", rdata); end
    rst = 1'b0;
    wait_init("midswap");
    model_identity();
    do_read(8'h01); do_read(8'h02); do_read(8'h10);
  endtask

  task automatic test_narrow_zero_fill();
    int n;
    rst2 = 1'b1; req2 = 1'b0; op2 = 2'b00; addr_a2 = '0; addr_b2 = '0; wdata2 = '0;
    cyc(); cyc();
    rst2 = 1'b0; n = 0;
    while (!ready2 && n < 100) begin cyc(); n++; end
    n_cmp++; if (n !== 16 || init_done2 !== 1'b1) begin n_err++; $display("FAIL w16_init: got %0d cycles done=%b expected 16,1", n, init_done2); end
    for (int i = 0; i < 16; i++) ref_mem2[i] = 16'h0000;
    ref_mem2[15] = 16'hBEEF;
    op2 = 2'b01; addr_a2 = 4'hF; wdata2 = 16'hBEEF; req2 = 1'b1;
    cyc();
    op2 = 2'b00;
    for (int i = 0; i < 16; i++) begin
      addr_a2 = 4'(i);
      cyc();
      n_cmp++; if (rvalid2 !== 1'b1 || rdata2 !== ref_mem2[i]) begin
        n_err++; $display("FAIL w16_read @%0d: got rvalid=%b rdata=%h expected 1,%h", i, rvalid2, rdata2, ref_mem2[i]);
      end
    end
    req2 = 1'b0;
    cyc();
    n_cmp++; if (rvalid2 !== 1'b0 || rdata2 !== 16'hBEEF) begin n_err++; $display("FAIL w16_hold: got rvalid=%b rdata=%h expected 0,beef", rvalid2, rdata2); end
  endtask

  initial begin
    rst2 = 1'b1; req2 = 1'b0; op2 = 2'b00; addr_a2 = '0; addr_b2 = '0; wdata2 = '0;
    test_reset();
    test_read_identity();
    test_write_then_read();
    test_swap();
    test_swap_same_and_rsvd();
    test_random_mix();
    test_reset_mid_swap();
    test_narrow_zero_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pearson_table_ram.md
Name: pearson_table_ram

Overview:
Parametrised, synchronous successor to the 256x8 Pearson permutation-table RAM.
- Self-initialises after reset. In identity mode every location holds its own address.
- Serves single-cycle reads and writes.
- Adds an atomic SWAP(a,b) operation, so the Pearson hash unit can reshuffle its permutation table in place without corrupting it.
- Sits between the Pearson hash datapath and the table-management controller.
- Replaces the tri-state bus with separate write-data and read-data ports.

Parameters:
DATA_WIDTH, 8, width of each table entry
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH is a derived localparam, not overridable
INIT_MODE, 0, fill pattern after reset: 0 = identity (mem[i]=i mod 2**DATA_WIDTH), 1 = all-zero

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  synchronous active-high reset
req_i  in  1  request valid; accepted only on a cycle where req_i=1 and ready_o=1
op_i  in  2  00 READ, 01 WRITE, 10 SWAP, 11 reserved
addr_a_i  in  ADDR_WIDTH  primary address (READ/WRITE target, SWAP operand A)
addr_b_i  in  ADDR_WIDTH  SWAP operand B; ignored for other ops
wdata_i  in  DATA_WIDTH  write data
ready_o  out  1  block can accept a request this cycle
rdata_o  out  DATA_WIDTH  read data; holds the last read value
rvalid_o  out  1  one-cycle pulse, rdata_o valid
done_o  out  1  one-cycle pulse on SWAP completion
init_done_o  out  1  table initialisation complete

Behaviour:
- Reset (rst_i=1 at an edge), taking priority over everything:
  - state=INIT, init counter=0.
  - ready_o=0, rvalid_o=0, done_o=0, init_done_o=0, rdata_o=0.
- INIT state:
  - Writes one word per cycle: mem[cnt] = (INIT_MODE==0) ? cnt[DATA_WIDTH-1:0] : 0, then cnt++.
  - After DEPTH write cycles it goes to IDLE; init_done_o=1 and ready_o=1 on the same edge.
  - First request can be accepted DEPTH+1 cycles after reset deasserts.
  - Requests during INIT are ignored.
- IDLE, READ accepted at edge E:
  - rdata_o=mem[addr_a_i] and rvalid_o=1 after E, for one cycle.
  - ready_o stays 1, so back-to-back reads run at 1/cycle.
- IDLE, WRITE accepted at edge E:
  - mem[addr_a_i]=wdata_i at E; ready_o stays 1; no rvalid_o.
  - A READ of the same address accepted at E+1 returns the new data.
- IDLE, SWAP accepted at edge E0 (addresses latched):
  - E0: tmp_a<=mem[a], state SW_RDB.
  - E1: tmp_b<=mem[b], state SW_WRA.
  - E2: mem[a]<=tmp_b, state SW_WRB.
  - E3: mem[b]<=tmp_a, done_o=1 for one cycle, state IDLE.
  - ready_o=0 in SW_RDB/SW_WRA/SW_WRB (exactly 3 cycles); rvalid_o is never asserted by a SWAP.
- SWAP with a==b: same 4-edge timing; contents unchanged; done_o still pulses.
- op_i=11 while accepted: no memory access, no pulses, state unchanged.
- req_i while ready_o=0: dropped, not queued; the requester must hold the request until ready_o=1.
- Reset mid-SWAP or mid-INIT: abort immediately; the table is fully reinitialised, so a partial swap is never visible.
- Memory array has single-port access: at most one read or one write per cycle in every state.
- No tri-state outputs anywhere.

Decomposition:
- Shared package pearson_pkg holds:
  - op encodings OP_READ/OP_WRITE/OP_SWAP/OP_RSVD;
  - FSM state enum INIT/IDLE/SW_RDB/SW_WRA/SW_WRB;
  - INIT_IDENTITY=0 and INIT_ZERO=1 constants.
- One sub-module, pearson_mem_core:
  - plain synchronous single-port DATA_WIDTH x DEPTH array (we, addr, wdata, registered rdata);
  - no reset on the array.
- The FSM, init counter, swap temporaries and output pulses live in pearson_table_ram.

Test Plan:
- Reset at defaults, then count cycles -> ready_o/init_done_o rise exactly 256 cycles after rst_i falls; READ addr 0x00, 0x7F, 0xFF -> rdata_o 0x00, 0x7F, 0xFF, each with a one-cycle rvalid_o.
- WRITE 0x3C->addr 0x10, then READ 0x10 next cycle -> rdata_o=0x3C; back-to-back READs 0x10, 0x11 -> 0x3C, 0x11 on consecutive cycles.
- SWAP a=0x05, b=0xFA on identity table -> ready_o low 3 cycles, done_o pulse 4 edges after accept; READ 0x05=0xFA, READ 0xFA=0x05; req_i pulsed during busy -> ignored.
- SWAP a=b=0x20, and op_i=11 at addr 0x20 -> mem[0x20] still 0x20, done_o pulses only for the SWAP, no rvalid_o.
- Assert rst_i at cycle E1 of SWAP(0x01,0x02) -> reinit; afterwards READ 0x01=0x01, READ 0x02=0x02.
- INIT_MODE=1, ADDR_WIDTH=4, DATA_WIDTH=16 -> init_done_o after 16 cycles, all reads 0x0000; WRITE 0xBEEF->0xF, READ 0xF -> 0xBEEF.
